// File: rtl/eth_ifm_pkg.sv
// Shared types, constants and helpers for the RX ingress frame module.
package eth_ifm_pkg;

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned STS_WORDS = 6;
  localparam int unsigned BEAT_W    = 73;
  localparam logic [31:0] STS_TAG   = 32'h5000_0000;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_DATA = 2'd1,
    IN_DROP = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_DATA = 2'd1,
    OUT_STS  = 2'd2
  } out_state_t;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // Status packet: tag word, three zero words, zero, then the byte length.
  function automatic logic [31:0] sts_word(input logic [2:0] idx, input logic [LEN_W-1:0] len);
    if (idx == 3'd0) return STS_TAG;
    if (idx == 3'(STS_WORDS - 1)) return 32'(len);
    return '0;
  endfunction

endpackage

// File: rtl/eth_ifm_frame_fifo.sv
// Synchronous FIFO with speculative write pointer; reads only see committed entries.
module eth_ifm_frame_fifo #(
  parameter int unsigned W          = 73,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         commit,
  input  logic         rewind,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, wr_ptr_nxt;
  logic          wr_go, rd_go;

  assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty      = (cmt_ptr == rd_ptr);
  assign wr_go      = wr_en && !full;
  assign rd_go      = rd_en && !empty;
  assign wr_ptr_nxt = wr_ptr + PW'(wr_go);
  assign rd_data    = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr[PW-2:0]] <= wr_data;
  end

  // Rewind wins over commit; commit includes a beat written in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (rewind) begin
        wr_ptr <= cmt_ptr;
      end else if (commit) begin
        wr_ptr  <= wr_ptr_nxt;
        cmt_ptr <= wr_ptr_nxt;
      end else begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (rd_go) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/eth_ifm.sv
// Store-and-forward RX ingress: buffers MAC frames, forwards good ones to DMA with a status packet.
module eth_ifm
  import eth_ifm_pkg::*;
#(
  parameter int unsigned C_DATA_DEPTH_LOG2 = 9,
  parameter int unsigned C_LEN_DEPTH_LOG2  = 4,
  parameter string       C_FAMILY          = ""
) (
  input  logic        rx_clk,
  input  logic        rx_reset,
  input  logic [63:0] rx_axis_mac_tdata,
  input  logic [7:0]  rx_axis_mac_tkeep,
  input  logic        rx_axis_mac_tlast,
  input  logic        rx_axis_mac_tuser,
  input  logic        rx_axis_mac_tvalid,
  output logic        rx_axis_mac_tready,
  output logic [63:0] rxd_tdata,
  output logic [7:0]  rxd_tkeep,
  output logic        rxd_tlast,
  output logic        rxd_tvalid,
  input  logic        rxd_tready,
  output logic [31:0] rxs_tdata,
  output logic [3:0]  rxs_tkeep,
  output logic        rxs_tlast,
  output logic        rxs_tvalid,
  input  logic        rxs_tready,
  output logic [3:0]  ifm_in_fsm_dbg,
  output logic [3:0]  ifm_out_fsm_dbg
);

  beat_t            d_wr_data, d_rd_data;
  logic             d_wr, d_commit, d_rewind, d_rd, d_full, d_empty;
  logic             l_wr, l_rd, l_full, l_empty;
  logic [LEN_W-1:0] l_rd_data, frame_len, cnt_q, cnt_d, cnt_base;
  logic [LEN_W:0]   cnt_sum;
  logic             beat_acc;
  in_state_t        in_q, in_d;
  out_state_t       out_q, out_d;
  logic             pulled_q, pulled_d;
  logic [2:0]       idx_q, idx_d;
  logic [63:0]      rxd_tdata_d;
  logic [7:0]       rxd_tkeep_d;
  logic             rxd_tlast_d, rxd_tvalid_d;
  logic [31:0]      rxs_tdata_d;
  logic             rxs_tlast_d, rxs_tvalid_d;

  assign beat_acc        = rx_axis_mac_tvalid && rx_axis_mac_tready;
  assign d_wr_data       = '{last: rx_axis_mac_tlast, keep: rx_axis_mac_tkeep, data: rx_axis_mac_tdata};
  assign rxs_tkeep       = {4{rxs_tvalid}};
  assign ifm_in_fsm_dbg  = {2'b00, in_q};
  assign ifm_out_fsm_dbg = {2'b00, out_q};

  eth_ifm_frame_fifo #(.W(BEAT_W), .DEPTH_LOG2(C_DATA_DEPTH_LOG2)) u_data_fifo (
    .clk(rx_clk), .rst(rx_reset),
    .wr_en(d_wr), .wr_data(d_wr_data), .commit(d_commit), .rewind(d_rewind),
    .rd_en(d_rd), .rd_data(d_rd_data), .full(d_full), .empty(d_empty)
  );

  eth_ifm_frame_fifo #(.W(LEN_W), .DEPTH_LOG2(C_LEN_DEPTH_LOG2)) u_len_fifo (
    .clk(rx_clk), .rst(rx_reset),
    .wr_en(l_wr), .wr_data(frame_len), .commit(l_wr), .rewind(1'b0),
    .rd_en(l_rd), .rd_data(l_rd_data), .full(l_full), .empty(l_empty)
  );

  always_ff @(posedge rx_clk or posedge rx_reset) begin
    if (rx_reset) begin
      rx_axis_mac_tready <= 1'b0;
      in_q               <= IN_IDLE;
      cnt_q              <= '0;
    end else begin
      rx_axis_mac_tready <= 1'b1;
      in_q               <= in_d;
      cnt_q              <= cnt_d;
    end
  end

  // Input side: write beats speculatively, commit or rewind on tlast.
  always_comb begin
    in_d      = in_q;
    cnt_d     = cnt_q;
    d_wr      = 1'b0;
    d_commit  = 1'b0;
    d_rewind  = 1'b0;
    l_wr      = 1'b0;
    cnt_base  = (in_q == IN_IDLE) ? '0 : cnt_q;
    cnt_sum   = {1'b0, cnt_base} + (LEN_W+1)'(popcount8(rx_axis_mac_tkeep));
    frame_len = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
    if (beat_acc) begin
      unique case (in_q)
        IN_IDLE, IN_DATA: begin
          if (d_full) begin
            d_rewind = rx_axis_mac_tlast;
            in_d     = rx_axis_mac_tlast ? IN_IDLE : IN_DROP;
          end else begin
            d_wr  = 1'b1;
            cnt_d = frame_len;
            if (rx_axis_mac_tlast) begin
              if (rx_axis_mac_tuser && !l_full && (frame_len != '0)) begin
                d_commit = 1'b1;
                l_wr     = 1'b1;
              end else begin
                d_rewind = 1'b1;
              end
              in_d = IN_IDLE;
            end else begin
              in_d = IN_DATA;
            end
          end
        end
        IN_DROP: begin
          if (rx_axis_mac_tlast) begin
            d_rewind = 1'b1;
            in_d     = IN_IDLE;
          end
        end
        default: in_d = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or posedge rx_reset) begin
    if (rx_reset) begin
      out_q      <= OUT_IDLE;
      pulled_q   <= 1'b0;
      idx_q      <= '0;
      rxd_tdata  <= '0;
      rxd_tkeep  <= '0;
      rxd_tlast  <= 1'b0;
      rxd_tvalid <= 1'b0;
      rxs_tdata  <= '0;
      rxs_tlast  <= 1'b0;
      rxs_tvalid <= 1'b0;
    end else begin
      out_q      <= out_d;
      pulled_q   <= pulled_d;
      idx_q      <= idx_d;
      rxd_tdata  <= rxd_tdata_d;
      rxd_tkeep  <= rxd_tkeep_d;
      rxd_tlast  <= rxd_tlast_d;
      rxd_tvalid <= rxd_tvalid_d;
      rxs_tdata  <= rxs_tdata_d;
      rxs_tlast  <= rxs_tlast_d;
      rxs_tvalid <= rxs_tvalid_d;
    end
  end

  // Output side: one-deep register stage on rxd; stop prefetching once the frame's tlast is pulled.
  always_comb begin
    out_d        = out_q;
    pulled_d     = pulled_q;
    idx_d        = idx_q;
    d_rd         = 1'b0;
    l_rd         = 1'b0;
    rxd_tdata_d  = rxd_tdata;
    rxd_tkeep_d  = rxd_tkeep;
    rxd_tlast_d  = rxd_tlast;
    rxd_tvalid_d = rxd_tvalid;
    rxs_tdata_d  = rxs_tdata;
    rxs_tlast_d  = rxs_tlast;
    rxs_tvalid_d = rxs_tvalid;
    unique case (out_q)
      OUT_IDLE: begin
        if (!l_empty) out_d = OUT_DATA;
      end
      OUT_DATA: begin
        if (rxd_tvalid && rxd_tready) begin
          rxd_tvalid_d = 1'b0;
          rxd_tlast_d  = 1'b0;
        end
        if ((!rxd_tvalid || rxd_tready) && !d_empty && !pulled_q) begin
          d_rd         = 1'b1;
          rxd_tdata_d  = d_rd_data.data;
          rxd_tkeep_d  = d_rd_data.keep;
          rxd_tlast_d  = d_rd_data.last;
          rxd_tvalid_d = 1'b1;
          pulled_d     = d_rd_data.last;
        end
        if (rxd_tvalid && rxd_tready && rxd_tlast) begin
          out_d        = OUT_STS;
          pulled_d     = 1'b0;
          idx_d        = '0;
          rxs_tdata_d  = STS_TAG;
          rxs_tlast_d  = 1'b0;
          rxs_tvalid_d = 1'b1;
        end
      end
      OUT_STS: begin
        if (rxs_tready) begin
          if (idx_q == 3'(STS_WORDS - 1)) begin
            rxs_tvalid_d = 1'b0;
            rxs_tlast_d  = 1'b0;
            l_rd         = 1'b1;
            out_d        = OUT_IDLE;
          end else begin
            idx_d       = idx_q + 3'd1;
            rxs_tdata_d = sts_word(idx_q + 3'd1, l_rd_data);
            rxs_tlast_d = ((idx_q + 3'd1) == 3'(STS_WORDS - 1));
          end
        end
      end
      default: out_d = OUT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_ifm.sv
// Scoreboard bench for eth_ifm: directed frames, overflow, backpressure and mid-frame reset.
`timescale 1ns/1ps
module tb_eth_ifm;

  logic        rx_clk = 1'b0;
  logic        rx_reset;
  logic [63:0] rx_axis_mac_tdata;
  logic [7:0]  rx_axis_mac_tkeep;
  logic        rx_axis_mac_tlast, rx_axis_mac_tuser, rx_axis_mac_tvalid, rx_axis_mac_tready;
  logic [63:0] rxd_tdata;
  logic [7:0]  rxd_tkeep;
  logic        rxd_tlast, rxd_tvalid;
  logic        rxd_tready = 1'b1;
  logic [31:0] rxs_tdata;
  logic [3:0]  rxs_tkeep;
  logic        rxs_tlast, rxs_tvalid;
  logic        rxs_tready = 1'b1;
  logic [3:0]  ifm_in_fsm_dbg, ifm_out_fsm_dbg;

  eth_ifm #(.C_DATA_DEPTH_LOG2(9), .C_LEN_DEPTH_LOG2(4), .C_FAMILY("")) dut (
    .rx_clk(rx_clk), .rx_reset(rx_reset),
    .rx_axis_mac_tdata(rx_axis_mac_tdata), .rx_axis_mac_tkeep(rx_axis_mac_tkeep),
    .rx_axis_mac_tlast(rx_axis_mac_tlast), .rx_axis_mac_tuser(rx_axis_mac_tuser),
    .rx_axis_mac_tvalid(rx_axis_mac_tvalid), .rx_axis_mac_tready(rx_axis_mac_tready),
    .rxd_tdata(rxd_tdata), .rxd_tkeep(rxd_tkeep), .rxd_tlast(rxd_tlast),
    .rxd_tvalid(rxd_tvalid), .rxd_tready(rxd_tready),
    .rxs_tdata(rxs_tdata), .rxs_tkeep(rxs_tkeep), .rxs_tlast(rxs_tlast),
    .rxs_tvalid(rxs_tvalid), .rxs_tready(rxs_tready),
    .ifm_in_fsm_dbg(ifm_in_fsm_dbg), .ifm_out_fsm_dbg(ifm_out_fsm_dbg)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last;} dbeat_t;
  typedef struct packed {logic [31:0] word; logic last;} sword_t;

  dbeat_t exp_d[$];
  sword_t exp_s[$];
  dbeat_t mon_d;
  sword_t mon_s;
  int     checks = 0, failures = 0;
  int     frames_exp = 0, sts_done = 0;
  bit     ignore_out = 1'b0, bp_en = 1'b0, stall = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Ready generator, updated 2ns after each edge.
  always @(posedge rx_clk) begin
    #2;
    rxd_tready = stall ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
    rxs_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: samples on the falling edge the handshakes that complete on the next rising edge.
  always @(negedge rx_clk) begin
    if (!rx_reset && !ignore_out) begin
      if (rxd_tvalid && rxd_tready) begin
        if (exp_d.size() == 0) chk("rxd_unexpected", {rxd_tdata, rxd_tkeep, rxd_tlast}, '0);
        else begin
          mon_d = exp_d.pop_front();
          chk("rxd_beat", {rxd_tdata, rxd_tkeep, rxd_tlast}, mon_d);
        end
      end
      if (rxs_tvalid) chk("rxs_tkeep", rxs_tkeep, 4'hF);
      if (rxs_tvalid && rxs_tready) begin
        if (exp_s.size() == 0) chk("rxs_unexpected", {rxs_tdata, rxs_tlast}, '0);
        else begin
          mon_s = exp_s.pop_front();
          chk("rxs_word", {rxs_tdata, rxs_tlast}, mon_s);
          if (mon_s.last) sts_done++;
        end
      end
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int n = 0;
    rx_axis_mac_tdata  = d;
    rx_axis_mac_tkeep  = k;
    rx_axis_mac_tlast  = l;
    rx_axis_mac_tuser  = u;
    rx_axis_mac_tvalid = 1'b1;
    while (!rx_axis_mac_tready && n < 100) begin
      @(posedge rx_clk); #1;
      n++;
    end
    if (n >= 100) chk("tready_timeout", 1'b0, 1'b1);
    @(posedge rx_clk); #1;
  endtask

  task automatic send_frame(input int nbeats, input logic [7:0] lastkeep, input bit good,
                            input bit expect_out, input logic [15:0] exp_len);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom};
      l = (b == nbeats - 1);
      k = l ? lastkeep : 8'hFF;
      if (expect_out) exp_d.push_back('{data: d, keep: k, last: l});
      drive_beat(d, k, l, l ? good : 1'b0);
    end
    rx_axis_mac_tvalid = 1'b0;
    if (expect_out) begin
      exp_s.push_back('{word: 32'h5000_0000, last: 1'b0});
      for (int w = 1; w < 5; w++) exp_s.push_back('{word: 32'h0, last: 1'b0});
      exp_s.push_back('{word: {16'h0, exp_len}, last: 1'b1});
      frames_exp++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_d.size() != 0 || exp_s.size() != 0) && n < 20000) begin
      @(posedge rx_clk); #1;
      n++;
    end
    if (n >= 20000) chk("drain_timeout", 1'b0, 1'b1);
    repeat (3) @(posedge rx_clk);
    #1;
  endtask

  task automatic throttle();
    int n = 0;
    while ((frames_exp - sts_done) >= 6 && n < 5000) begin
      @(posedge rx_clk); #1;
      n++;
    end
    if (n >= 5000) chk("throttle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int nb, kb;
    rx_reset           = 1'b1;
    rx_axis_mac_tdata  = '0;
    rx_axis_mac_tkeep  = '0;
    rx_axis_mac_tlast  = 1'b0;
    rx_axis_mac_tuser  = 1'b0;
    rx_axis_mac_tvalid = 1'b0;
    #2;
    chk("rst_rxd_tvalid", rxd_tvalid, 1'b0);
    chk("rst_rxs_tvalid", rxs_tvalid, 1'b0);
    chk("rst_rxd_tlast", rxd_tlast, 1'b0);
    chk("rst_rxs_tlast", rxs_tlast, 1'b0);
    chk("rst_tready", rx_axis_mac_tready, 1'b0);
    chk("rst_in_dbg", ifm_in_fsm_dbg, 4'd0);
    chk("rst_out_dbg", ifm_out_fsm_dbg, 4'd0);
    repeat (3) @(posedge rx_clk);
    #1 rx_reset = 1'b0;

    // 64-byte and 61-byte good frames
    send_frame(8, 8'hFF, 1'b1, 1'b1, 16'h0040);
    drain();
    send_frame(8, 8'h1F, 1'b1, 1'b1, 16'h003D);
    drain();

    // bad frame sandwiched between good frames
    send_frame(3, 8'h0F, 1'b1, 1'b1, 16'h0014);
    send_frame(5, 8'hFF, 1'b0, 1'b0, 16'h0000);
    send_frame(1, 8'h01, 1'b1, 1'b1, 16'h0001);
    drain();

    // overflow: 600 beats into a 512-beat FIFO with the DMA stalled
    stall = 1'b1;
    repeat (2) @(posedge rx_clk);
    #1;
    for (int b = 0; b < 600; b++) begin
      drive_beat({32'hDEAD_0000, 32'(b)}, 8'hFF, (b == 599), (b == 599));
      if (b == 511) chk("ovf_dbg_data", ifm_in_fsm_dbg, 4'd1);
      if (b == 512) chk("ovf_dbg_drop", ifm_in_fsm_dbg, 4'd2);
    end
    rx_axis_mac_tvalid = 1'b0;
    chk("ovf_dbg_idle", ifm_in_fsm_dbg, 4'd0);
    repeat (6) @(posedge rx_clk);
    #1;
    chk("ovf_no_output", rxd_tvalid, 1'b0);
    stall = 1'b0;
    send_frame(8, 8'hFF, 1'b1, 1'b1, 16'h0040);
    drain();

    // random backpressure over 100 frames
    bp_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      throttle();
      nb = $urandom_range(1, 8);
      kb = $urandom_range(1, 8);
      send_frame(nb, 8'hFF >> (8 - kb), (i % 7 != 3), (i % 7 != 3), 16'((nb - 1) * 8 + kb));
    end
    drain();
    bp_en = 1'b0;

    // reset with an output frame mid-transfer and an input frame mid-flight
    ignore_out = 1'b1;
    stall      = 1'b1;
    send_frame(4, 8'hFF, 1'b1, 1'b0, 16'h0000);
    repeat (6) @(posedge rx_clk);
    #1 stall = 1'b0;
    @(posedge rx_clk);
    #1 stall = 1'b1;
    repeat (2) @(posedge rx_clk);
    #1;
    for (int b = 0; b < 3; b++) drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    chk("pre_rst_rxd_tvalid", rxd_tvalid, 1'b1);
    chk("pre_rst_in_dbg", ifm_in_fsm_dbg, 4'd1);
    chk("pre_rst_out_dbg", ifm_out_fsm_dbg, 4'd1);
    rx_reset = 1'b1;
    #1;
    chk("mid_rst_rxd_tvalid", rxd_tvalid, 1'b0);
    chk("mid_rst_rxs_tvalid", rxs_tvalid, 1'b0);
    chk("mid_rst_tready", rx_axis_mac_tready, 1'b0);
    chk("mid_rst_in_dbg", ifm_in_fsm_dbg, 4'd0);
    chk("mid_rst_out_dbg", ifm_out_fsm_dbg, 4'd0);
    rx_axis_mac_tvalid = 1'b0;
    repeat (2) @(posedge rx_clk);
    #1 rx_reset = 1'b0;
    stall      = 1'b0;
    ignore_out = 1'b0;
    send_frame(8, 8'hFF, 1'b1, 1'b1, 16'h0040);
    drain();

    chk("frames_complete", 32'(sts_done), 32'(frames_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
